// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the RAM port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESP    = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_align_check.sv
// rtl/mem_align_check.sv - flags an address that is not naturally aligned for its access size
module mem_align_check
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic       o_misaligned
);

    always_comb begin
        o_misaligned = 1'b0;
        case (i_size)
            SZ_BYTE: o_misaligned = 1'b0;
            SZ_HALF: o_misaligned = i_addr_lo[0];
            default: o_misaligned = |i_addr_lo;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter owning the single MFA/MFC RAM port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_f_req,
    input  logic [31:0] i_f_addr,
    output logic        o_f_ack,
    output logic        o_f_err,
    input  logic        i_d_req,
    input  logic        i_d_we,
    input  logic [1:0]  i_d_size,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    output logic        o_d_ack,
    output logic        o_d_err,
    output logic [31:0] o_rsp_rdata,
    output logic        o_mfa,
    output logic        o_mem_we,
    output logic [1:0]  o_mem_size,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mfc,
    output logic        o_busy
);

    localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e      r_state;
    req_id_e     r_last_grant;
    req_id_e     r_gnt;
    logic [CNT_W-1:0] r_cnt;
    logic        r_f_ack, r_f_err, r_d_ack, r_d_err;
    logic        r_mfa, r_mem_we;
    logic [1:0]  r_mem_size;
    logic [31:0] r_mem_addr, r_mem_wdata, r_rsp_rdata;

    logic        w_gnt_d;
    logic        w_any;
    logic        w_misaligned;
    logic [1:0]  w_sel_size;
    logic [31:0] w_sel_addr;
    req_id_e     w_gnt_id;

    // Data wins a tie only when fetch was the last one served; a stale MFC blocks new grants.
    assign w_gnt_d    = i_d_req & (~i_f_req | (r_last_grant == REQ_FETCH));
    assign w_any      = (i_f_req | i_d_req) & ~i_mfc;
    assign w_gnt_id   = w_gnt_d ? REQ_DATA : REQ_FETCH;
    assign w_sel_size = !w_gnt_d ? SZ_WORD : ((i_d_size == 2'd3) ? SZ_WORD : i_d_size);
    assign w_sel_addr = w_gnt_d ? i_d_addr : i_f_addr;

    mem_align_check u_align (
        .i_size       (w_sel_size),
        .i_addr_lo    (w_sel_addr[1:0]),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= REQ_DATA;
            r_gnt        <= REQ_FETCH;
            r_cnt        <= '0;
            r_f_ack      <= 1'b0;
            r_f_err      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_d_err      <= 1'b0;
            r_mfa        <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_size   <= 2'd0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rsp_rdata  <= '0;
        end else begin
            r_f_ack <= 1'b0;
            r_f_err <= 1'b0;
            r_d_ack <= 1'b0;
            r_d_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_last_grant <= w_gnt_id;
                        r_gnt        <= w_gnt_id;
                        if (w_misaligned) begin
                            r_f_ack <= ~w_gnt_d;
                            r_f_err <= ~w_gnt_d;
                            r_d_ack <= w_gnt_d;
                            r_d_err <= w_gnt_d;
                            r_state <= ST_RESP;
                        end else begin
                            r_mem_addr  <= w_sel_addr;
                            r_mem_size  <= w_sel_size;
                            r_mem_we    <= w_gnt_d & i_d_we;
                            r_mem_wdata <= w_gnt_d ? i_d_wdata : 32'd0;
                            r_mfa       <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (i_mfc) begin
                        if (!r_mem_we) r_rsp_rdata <= i_mem_rdata;
                        r_mfa   <= 1'b0;
                        r_f_ack <= (r_gnt == REQ_FETCH);
                        r_d_ack <= (r_gnt == REQ_DATA);
                        r_state <= ST_RESP;
                    end else if (r_cnt == LP_TMO_LAST) begin
                        r_rsp_rdata <= '0;
                        r_mfa       <= 1'b0;
                        r_f_ack     <= (r_gnt == REQ_FETCH);
                        r_f_err     <= (r_gnt == REQ_FETCH);
                        r_d_ack     <= (r_gnt == REQ_DATA);
                        r_d_err     <= (r_gnt == REQ_DATA);
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP:    r_state <= i_mfc ? ST_RECOVER : ST_IDLE;
                ST_RECOVER: if (!i_mfc) r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_f_ack     = r_f_ack;
    assign o_f_err     = r_f_err;
    assign o_d_ack     = r_d_ack;
    assign o_d_err     = r_d_err;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_mfa       = r_mfa;
    assign o_mem_we    = r_mem_we;
    assign o_mem_size  = r_mem_size;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mfc = 1'b0;
    logic [31:0] f_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [1:0]  d_size = 2'd0;
    logic        f_ack, f_err, d_ack, d_err, mfa, mem_we, busy;
    logic [1:0]  mem_size;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata;

    int total = 0;
    int bad   = 0;
    logic pre_mfa = 1'b0, pre_mfc = 1'b0;

    mem_port_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_ack(f_ack), .o_f_err(f_err),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_size(d_size), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .o_d_ack(d_ack), .o_d_err(d_err),
        .o_rsp_rdata(rsp_rdata), .o_mfa(mfa), .o_mem_we(mem_we),
        .o_mem_size(mem_size), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mfc(mfc), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pre_mfa <= mfa;
        pre_mfc <= mfc;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (f_ack && d_ack) begin
                bad++;
                $display("FAIL ack_exclusive: f_ack=%b d_ack=%b required not both 1", f_ack, d_ack);
            end
            total++;
            if (mfa && !pre_mfa && pre_mfc) begin
                bad++;
                $display("FAIL mfa_rise_under_mfc: mfa rose while mfc=1, required no rise");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input logic [31:0] rd, input int dly,
                         output logic got_f, output logic got_d, output logic ok);
        int n = 0;
        got_f = 1'b0;
        got_d = 1'b0;
        while (!mfa && n < 20) begin
            step();
            n++;
        end
        ok = mfa;
        if (ok) begin
            repeat (dly) step();
            mfc = 1'b1;
            mem_rdata = rd;
            step();
            got_f = f_ack;
            got_d = d_ack;
            mfc = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        total++; if (mfa !== 1'b0) begin bad++; $display("FAIL reset_mfa: got %b want 0", mfa); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({f_ack, d_ack, f_err, d_err} !== 4'b0) begin bad++; $display("FAIL reset_acks: got %b want 0000", {f_ack, d_ack, f_err, d_err}); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp: got %h want 0", rsp_rdata); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        f_addr = 32'h40;
        f_req  = 1'b1;
        step();
        total++; if (mfa !== 1'b1) begin bad++; $display("FAIL fetch_mfa: got %b want 1", mfa); end
        total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL fetch_addr: got %h want 00000040", mem_addr); end
        total++; if ({mem_we, mem_size} !== 3'b010) begin bad++; $display("FAIL fetch_op: got %b want 010", {mem_we, mem_size}); end
        step();
        step();
        step();
        mfc = 1'b1;
        mem_rdata = 32'hA2044012;
        total++; if (f_ack !== 1'b0) begin bad++; $display("FAIL fetch_early_ack: got %b want 0", f_ack); end
        step();
        total++; if ({f_ack, f_err, d_ack} !== 3'b100) begin bad++; $display("FAIL fetch_ack: got %b want 100", {f_ack, f_err, d_ack}); end
        total++; if (rsp_rdata !== 32'hA2044012) begin bad++; $display("FAIL fetch_rdata: got %h want a2044012", rsp_rdata); end
        total++; if (mfa !== 1'b0) begin bad++; $display("FAIL fetch_mfa_drop: got %b want 0", mfa); end
        f_req = 1'b0;
        mfc = 1'b0;
        step();
        total++; if ({f_ack, busy} !== 2'b00) begin bad++; $display("FAIL fetch_idle: got %b want 00", {f_ack, busy}); end
    endtask

    task automatic test_misaligned_and_store();
        logic gf, gd, ok;
        d_we = 1'b1; d_size = 2'd1; d_addr = 32'h103; d_wdata = 32'h1111;
        d_req = 1'b1;
        step();
        total++; if ({d_ack, d_err, f_ack, mfa} !== 4'b1100) begin bad++; $display("FAIL misalign_ack: got %b want 1100", {d_ack, d_err, f_ack, mfa}); end
        d_req = 1'b0;
        step();
        total++; if ({d_ack, mfa, busy} !== 3'b000) begin bad++; $display("FAIL misalign_after: got %b want 000", {d_ack, mfa, busy}); end
        total++; if (rsp_rdata !== 32'hA2044012) begin bad++; $display("FAIL misalign_rsp_hold: got %h want a2044012", rsp_rdata); end
        d_addr = 32'h102; d_wdata = 32'hBEEF;
        d_req = 1'b1;
        step();
        total++; if ({mfa, mem_we, mem_size} !== 4'b1101) begin bad++; $display("FAIL store_op: got %b want 1101", {mfa, mem_we, mem_size}); end
        total++; if (mem_addr !== 32'h102 || mem_wdata !== 32'hBEEF) begin bad++; $display("FAIL store_bus: got %h/%h want 00000102/0000beef", mem_addr, mem_wdata); end
        serve(32'h12345678, 1, gf, gd, ok);
        total++; if ({ok, gd, gf, d_err} !== 4'b1100) begin bad++; $display("FAIL store_ack: got %b want 1100", {ok, gd, gf, d_err}); end
        total++; if (rsp_rdata !== 32'hA2044012) begin bad++; $display("FAIL store_rsp_hold: got %h want a2044012", rsp_rdata); end
        d_req = 1'b0; d_we = 1'b0;
        step();
    endtask

    task automatic test_arbitration();
        logic gf, gd, ok;
        logic [31:0] rd;
        test_reset();
        f_addr = 32'h100; d_addr = 32'h200; d_size = 2'd2; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd = 32'hD000_0000 + 32'(i);
            serve(rd, 1, gf, gd, ok);
            if (i == 3) begin f_req = 1'b0; d_req = 1'b0; end
            total++;
            if ({ok, gf, gd} !== {1'b1, (i % 2 == 0), (i % 2 == 1)}) begin
                bad++;
                $display("FAIL arb_order%0d: got ok/f/d=%b want %b", i, {ok, gf, gd}, {1'b1, (i % 2 == 0), (i % 2 == 1)});
            end
            total++;
            if (rsp_rdata !== rd) begin bad++; $display("FAIL arb_rdata%0d: got %h want %h", i, rsp_rdata, rd); end
        end
        step();
    endtask

    task automatic test_timeout();
        int n = 0;
        d_we = 1'b0; d_size = 2'd2; d_addr = 32'h80;
        d_req = 1'b1;
        step();
        while (mfa && n < 100) begin
            n++;
            step();
        end
        total++; if (n !== 64) begin bad++; $display("FAIL timeout_len: got %0d mfa cycles want 64", n); end
        total++; if ({d_ack, d_err, f_ack} !== 3'b110) begin bad++; $display("FAIL timeout_ack: got %b want 110", {d_ack, d_err, f_ack}); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL timeout_rsp: got %h want 0", rsp_rdata); end
        d_req = 1'b0;
        step();
    endtask

    task automatic test_recover();
        f_addr = 32'h44; f_req = 1'b1;
        step();
        step();
        mfc = 1'b1; mem_rdata = 32'h55AA00FF;
        f_req = 1'b0;
        d_addr = 32'h84; d_size = 2'd2; d_we = 1'b0; d_req = 1'b1;
        step();
        total++; if ({f_ack, f_err} !== 2'b10 || rsp_rdata !== 32'h55AA00FF) begin bad++; $display("FAIL recover_first: got ack/err=%b rsp=%h want 10/55aa00ff", {f_ack, f_err}, rsp_rdata); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({mfa, busy} !== 2'b01) begin bad++; $display("FAIL recover_hold%0d: got mfa/busy=%b want 01", i, {mfa, busy}); end
        end
        mfc = 1'b0;
        step();
        total++; if (mfa !== 1'b0) begin bad++; $display("FAIL recover_exit: got %b want 0", mfa); end
        step();
        total++; if (mfa !== 1'b1 || mem_addr !== 32'h84) begin bad++; $display("FAIL recover_next: got mfa=%b addr=%h want 1/00000084", mfa, mem_addr); end
        step();
        mfc = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        total++; if ({d_ack, d_err} !== 2'b10 || rsp_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL recover_data: got %b/%h want 10/0badf00d", {d_ack, d_err}, rsp_rdata); end
        mfc = 1'b0; d_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic gf, gd, ok;
        f_addr = 32'h48; f_req = 1'b1;
        step();
        step();
        total++; if (mfa !== 1'b1) begin bad++; $display("FAIL midrst_pre: got %b want 1", mfa); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({mfa, busy} !== 2'b00) begin bad++; $display("FAIL midrst_mfa: got %b want 00", {mfa, busy}); end
        f_req = 1'b0;
        step();
        step();
        total++; if ({f_ack, d_ack} !== 2'b00) begin bad++; $display("FAIL midrst_noack: got %b want 00", {f_ack, d_ack}); end
        rst_n = 1'b1;
        step();
        total++; if ({f_ack, d_ack, mfa} !== 3'b000) begin bad++; $display("FAIL midrst_release: got %b want 000", {f_ack, d_ack, mfa}); end
        f_addr = 32'h4C; f_req = 1'b1;
        serve(32'hC0FFEE01, 2, gf, gd, ok);
        f_req = 1'b0;
        total++; if ({ok, gf, gd, f_err} !== 4'b1100 || rsp_rdata !== 32'hC0FFEE01) begin bad++; $display("FAIL midrst_fresh: got %b rsp=%h want 1100/c0ffee01", {ok, gf, gd, f_err}, rsp_rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_misaligned_and_store();
        test_arbitration();
        test_timeout();
        test_recover();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
